// File: rtl/svc_tb_rv_pkg.sv
// Shared types and constants for the ready/valid sink checker.
// The backpressure modes and the LFSR feedback rule live here so bench-side code can reuse them.
package svc_tb_rv_pkg;

  typedef enum logic [1:0] {
    BP_ALWAYS = 2'd0,
    BP_ALT    = 2'd1,
    BP_LFSR   = 2'd2,
    BP_NEVER  = 2'd3
  } bp_mode_t;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits 15..0.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_feedback(input logic [15:0] state);
    return ^(state & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/svc_sync_fifo.sv
// Single-clock FIFO with a registered head word and full/empty flags from registered state.
// The head register shows the oldest entry one cycle after it becomes the oldest.
module svc_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [AW-1:0]         rd_addr;
  logic [AW:0]           count_reg;
  logic [DATA_WIDTH-1:0] head_reg;
  logic                  push;
  logic                  pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_addr = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
  assign rd_data = head_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage and head read stay reset-free so the array maps onto block RAM.
  // A write landing on the next head address is forwarded, since the RAM reads old data.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
    if (push && (wr_ptr_reg == rd_addr)) head_reg <= wr_data;
    else                                 head_reg <= mem[rd_addr];
  end

endmodule

// File: rtl/svc_tb_rv_checker.sv
// Ready/valid sink that accepts DUT beats under selectable backpressure and
// checks them in order against expectations queued by the bench.
module svc_tb_rv_checker
  import svc_tb_rv_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter int          EXP_DEPTH  = 16,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            bp_mode,
  input  logic                  exp_valid,
  input  logic [DATA_WIDTH-1:0] exp_data,
  output logic                  exp_ready,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic                  err,
  output logic                  unexpected,
  output logic [CNT_WIDTH-1:0]  first_err_idx,
  output logic [DATA_WIDTH-1:0] first_err_got,
  output logic [DATA_WIDTH-1:0] first_err_exp,
  output logic                  exp_empty
);

  genvar gi;

  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  toggle_reg;
  logic [15:0]           lfsr_reg;
  logic [15:0]           lfsr_next;
  bp_mode_t              bp_sel;
  logic                  acc;
  logic                  pop;
  logic                  unexp_evt;
  logic                  mismatch;
  logic                  err_evt;
  logic [DATA_WIDTH-1:0] exp_at_err;

  logic [CNT_WIDTH-1:0]  beat_cnt_reg;
  logic [CNT_WIDTH-1:0]  err_cnt_reg;
  logic                  err_reg;
  logic                  unexpected_reg;
  logic [CNT_WIDTH-1:0]  first_idx_reg;
  logic [DATA_WIDTH-1:0] first_got_reg;
  logic [DATA_WIDTH-1:0] first_exp_reg;

  svc_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (EXP_DEPTH)
  ) u_exp_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (exp_valid),
    .wr_data (exp_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign exp_ready = !fifo_full;
  assign exp_empty = fifo_empty;

  // Left-shifting Fibonacci LFSR; the new bit enters at position 0.
  assign lfsr_next[0] = lfsr_feedback(lfsr_reg);
  generate
    for (gi = 1; gi < 16; gi++) begin : g_lfsr_shift
      assign lfsr_next[gi] = lfsr_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_reg <= 1'b0;
      lfsr_reg   <= LFSR_SEED;
    end else begin
      toggle_reg <= !toggle_reg;
      lfsr_reg   <= lfsr_next;
    end
  end

  assign bp_sel = bp_mode_t'(bp_mode);

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (bp_sel)
        BP_ALWAYS: in_ready = 1'b1;
        BP_ALT:    in_ready = toggle_reg;
        BP_LFSR:   in_ready = lfsr_reg[0];
        BP_NEVER:  in_ready = 1'b0;
        default:   in_ready = 1'b0;
      endcase
    end
  end

  // Readiness ignores FIFO occupancy so surplus DUT beats still get accepted and flagged.
  assign acc        = in_valid && in_ready;
  assign pop        = acc && !fifo_empty;
  assign unexp_evt  = acc && fifo_empty;
  assign mismatch   = pop && (in_data != fifo_head);
  assign err_evt    = mismatch || unexp_evt;
  assign exp_at_err = fifo_empty ? '0 : fifo_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_reg   <= '0;
      err_cnt_reg    <= '0;
      err_reg        <= 1'b0;
      unexpected_reg <= 1'b0;
      first_idx_reg  <= '0;
      first_got_reg  <= '0;
      first_exp_reg  <= '0;
    end else begin
      if (acc && (beat_cnt_reg != '1)) beat_cnt_reg <= beat_cnt_reg + CNT_WIDTH'(1);
      if (err_evt && (err_cnt_reg != '1)) err_cnt_reg <= err_cnt_reg + CNT_WIDTH'(1);
      if (err_evt)   err_reg        <= 1'b1;
      if (unexp_evt) unexpected_reg <= 1'b1;
      // Only the error that first raises err is recorded.
      if (err_evt && !err_reg) begin
        first_idx_reg <= beat_cnt_reg;
        first_got_reg <= in_data;
        first_exp_reg <= exp_at_err;
      end
    end
  end

  assign beat_cnt      = beat_cnt_reg;
  assign err_cnt       = err_cnt_reg;
  assign err           = err_reg;
  assign unexpected    = unexpected_reg;
  assign first_err_idx = first_idx_reg;
  assign first_err_got = first_got_reg;
  assign first_err_exp = first_exp_reg;

endmodule

// File: doc/svc_tb_rv_checker.md
Name: svc_tb_rv_checker

Overview:
- Synthesizable ready/valid sink for unit benches; it is the consumer end of a DUT's ready/valid output.
- The bench pushes expected beats into an internal expectation FIFO.
- The checker accepts DUT beats under a selectable backpressure pattern, compares each accepted beat in order, and counts beats and errors.
- Bench tasks read its status outputs to assert pass or fail.

Parameters:
DATA_WIDTH, 8, width of the data bus compared
EXP_DEPTH, 16, expectation FIFO depth (power of 2, ≥2)
CNT_WIDTH, 16, width of the beat and error counters
LFSR_SEED, 16'hACE1, reset value of the backpressure LFSR (nonzero)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
bp_mode  in  2  backpressure select: 0 always, 1 alternate, 2 LFSR, 3 never
exp_valid  in  1  bench pushes an expected beat
exp_data  in  DATA_WIDTH  expected value
exp_ready  out  1  expectation FIFO not full
in_valid  in  1  DUT beat valid
in_data  in  DATA_WIDTH  DUT beat data
in_ready  out  1  checker accepts the DUT beat
beat_cnt  out  CNT_WIDTH  accepted DUT beats
err_cnt  out  CNT_WIDTH  mismatched or unexpected beats
err  out  1  sticky; set on the first error
unexpected  out  1  sticky; a beat was accepted while the FIFO was empty
first_err_idx  out  CNT_WIDTH  beat_cnt value at the first error
first_err_got  out  DATA_WIDTH  in_data at the first error
first_err_exp  out  DATA_WIDTH  FIFO head at the first error (0 if unexpected)
exp_empty  out  1  expectation FIFO empty (all expectations consumed)

Behaviour:
- Reset (rst high at a clk edge):
  - FIFO empties; exp_ready=1 and exp_empty=1 after the edge.
  - Counters, err, unexpected and first_err_* all go to 0.
  - The toggle bit goes to 0 and the LFSR loads LFSR_SEED.
  - While rst is high, in_ready is forced to 0.
  - Reset mid-stream discards all pending expectations.
- Push: when exp_valid && exp_ready, exp_data is written at the edge. exp_ready = !full, driven from registered state only; there is no same-cycle pop bypass when full.
- Accept: acc = in_valid && in_ready. in_ready does not depend on FIFO state, so surplus beats are detected.
- in_ready by bp_mode (combinational from bp_mode and registered state):
  - 0 → 1.
  - 1 → toggle bit. Toggle flips every cycle after reset, so in_ready is 0 in the first cycle after reset, then alternates.
  - 2 → lfsr[0]. 16-bit Fibonacci LFSR, taps 16,14,13,11, shifts every cycle regardless of mode.
  - 3 → 0.
  - bp_mode may change on any cycle and takes effect the same cycle.
- On acc with FIFO non-empty: compare in_data to the registered FIFO head, then pop. On mismatch, err_cnt increments.
- On acc with FIFO empty: unexpected=1 and err_cnt increments. The FIFO head is not read.
- Same-cycle push and accept:
  - The pushed entry is not visible to the compare that cycle.
  - With the FIFO empty, the beat counts as unexpected.
  - With the FIFO non-empty, occupancy stays unchanged.
- err = (err_cnt != 0), registered and sticky.
- first_err_* are captured only on the error that takes err from 0 to 1. first_err_idx is beat_cnt before its increment, i.e. a 0-based beat index.
- beat_cnt increments on every acc. beat_cnt and err_cnt saturate at all-ones.
- Latency: status outputs reflect an accept one cycle after the accepting edge.
- in_data is ignored when acc is 0. X on in_data while in_valid=0 must not corrupt state.

Decomposition:
- Package svc_tb_rv_pkg:
  - bp_mode_t enum {BP_ALWAYS, BP_ALT, BP_LFSR, BP_NEVER}.
  - LFSR tap-mask constant 16'hB400.
- Sub-module: reuse svc_sync_fifo (DATA_WIDTH, EXP_DEPTH) for the expectation queue, with a registered head output and full/empty flags.
- Top level: backpressure generator, compare/capture logic, counters.

Test Plan:
- bp_mode=0; push 1,2,3,4; DUT sends 1,2,3,4 back-to-back → 4 accepts in 4 cycles, beat_cnt=4, err=0, exp_empty=1.
- bp_mode=1; push 8'hA0..A3; DUT holds valid → accepts only on alternate cycles (8 cycles), beat_cnt=4, err_cnt=0.
- bp_mode=0; push 5,6,7; DUT sends 5,9,7 → err=1, err_cnt=1, first_err_idx=1, first_err_got=9, first_err_exp=6.
- FIFO empty; DUT sends 8'h33 → unexpected=1, err_cnt=1, first_err_idx=0, first_err_exp=0.
- Push 16 entries → exp_ready=0 after the 16th; a 17th push is held off. Reset asserted with 16 pending → next cycle exp_empty=1, counters 0, in_ready 0 during reset.
- bp_mode=3 for 10 cycles with DUT valid → beat_cnt unchanged. Switch to bp_mode=2 → beats accepted exactly on cycles where lfsr[0]=1, matching a bench reference model seeded 16'hACE1.
